fetch_unit: RTL and testbench

Instruction-fetch stage placed directly upstream of the `insmem` instruction memory.
- Holds the program counter and drives `addr_code` into `insmem`.
- Captures the returned 32-bit `code` into an instruction register (IR) for the decode stage.
- Supports stall, absolute jump and PC-relative branch redirection, with optional halt detection.

---
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, drives insmem, registers the returned word into IR.
// Latency: word at addr_code appears in ir one rising edge later; redirects cost one bubble.
// Backpressure: stall freezes PC and IR; optional halt (FETCH_HALT_EN) freezes fetch until rst.
module fetch_unit #(
  parameter int unsigned          AW        = 6,
  parameter int unsigned          DW        = 32,
  parameter logic [AW-1:0]        RESET_PC  = '0,
  parameter logic [DW-1:0]        HALT_WORD = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_off,
  output logic [AW-1:0] addr_code,
  input  logic [DW-1:0] code,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  output logic          halted
);

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_seq;
  logic [AW-1:0] branch_tgt;

  // insmem is combinational, so the fetch address is simply the PC
  assign addr_code = pc;

  // Offset is relative to the instruction after the one in IR; AW-bit add wraps,
  // which is the same as sign-extending the offset and truncating.
  assign pc_seq     = pc + AW'(1);
  assign branch_tgt = ir_pc + AW'(1) + branch_off;

`ifdef FETCH_HALT_EN
  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  // Fetch FSM: stall > jump > branch > sequential fetch; HALT is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            // hold everything; redirects are re-presented after the stall
          end else if (jump_en) begin
            pc       <= jump_addr;
            ir_valid <= 1'b0;
          end else if (branch_en) begin
            pc       <= branch_tgt;
            ir_valid <= 1'b0;
          end else begin
            ir       <= code;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (code == HALT_WORD) begin
              // halt word is delivered to decode once, then fetch stops in place
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_seq;
            end
          end
        end
        HALT: begin
          ir_valid <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;
  assign halted           = 1'b0;

  // Fetch pipeline register: stall > jump > branch > sequential fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (stall) begin
        // hold everything; redirects are re-presented after the stall
      end else if (jump_en) begin
        pc       <= jump_addr;
        ir_valid <= 1'b0;
      end else if (branch_en) begin
        pc       <= branch_tgt;
        ir_valid <= 1'b0;
      end else begin
        ir       <= code;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
        pc       <= pc_seq;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction-memory model.
// Checks are taken 1 time unit after each rising edge; inputs change there too.
// Halt-specific expectations follow whether FETCH_HALT_EN is defined for the build.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [5:0]  jump_addr;
  logic        branch_en;
  logic [5:0]  branch_off;
  logic [5:0]  addr_code;
  logic [31:0] code;
  logic [31:0] ir;
  logic [5:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        halt_at4;

  int tests;
  int fails;

  fetch_unit #(
    .AW(6), .DW(32), .RESET_PC(6'd0), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_en(branch_en), .branch_off(branch_off),
    .addr_code(addr_code), .code(code),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [5:0] a);
    return {16'hC0DE, 10'd0, a};
  endfunction

  // instruction memory: distinct word per address, optional halt word at 4
  always_comb begin
    code = word_at(addr_code);
    if (halt_at4 && addr_code == 6'd4) code = 32'hFFFF_FFFF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [5:0] e_addr,
                             input logic [5:0] e_irpc, input logic [31:0] e_ir,
                             input logic e_vld);
    check({tag, ".addr"}, 32'(addr_code), 32'(e_addr));
    check({tag, ".ir_pc"}, 32'(ir_pc), 32'(e_irpc));
    check({tag, ".ir"}, ir, e_ir);
    check({tag, ".vld"}, 32'(ir_valid), 32'(e_vld));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
    branch_en = 1'b0; branch_off = '0; halt_at4 = 1'b0;
    #2;
    check_state("reset", 6'd0, 6'd0, 32'd0, 1'b0);
    check("reset.halted", 32'(halted), 32'd0);
    #10 rst = 1'b0;

    // sequential fetch: ir_pc lags addr_code by one
    for (int k = 1; k <= 6; k++) begin
      step();
      check_state($sformatf("seq%0d", k), 6'(k), 6'(k - 1), word_at(6'(k - 1)), 1'b1);
    end

    // stall for 3 cycles at ir_pc=5; a jump request during stall is ignored
    stall = 1'b1; jump_en = 1'b1; jump_addr = 6'd33;
    for (int k = 0; k < 3; k++) begin
      step();
      check_state($sformatf("stall%0d", k), 6'd6, 6'd5, word_at(6'd5), 1'b1);
    end
    stall = 1'b0; jump_en = 1'b0;
    step();
    check_state("unstall", 6'd7, 6'd6, word_at(6'd6), 1'b1);
    step();
    check_state("pre_jump", 6'd8, 6'd7, word_at(6'd7), 1'b1);

    // jump at pc=8 to 20: one bubble, ir/ir_pc hold
    jump_en = 1'b1; jump_addr = 6'd20;
    step();
    check_state("jump_bubble", 6'd20, 6'd7, word_at(6'd7), 1'b0);
    jump_en = 1'b0;
    step();
    check_state("jump_tgt", 6'd21, 6'd20, word_at(6'd20), 1'b1);

    // get ir_pc=2 via a jump, then branch by -5 -> 62
    jump_en = 1'b1; jump_addr = 6'd2;
    step();
    jump_en = 1'b0;
    step();
    check_state("at2", 6'd3, 6'd2, word_at(6'd2), 1'b1);
    branch_en = 1'b1; branch_off = 6'b111011;
    step();
    check_state("br_bubble", 6'd62, 6'd2, word_at(6'd2), 1'b0);
    branch_en = 1'b0;
    step();
    check_state("br_tgt", 6'd63, 6'd62, word_at(6'd62), 1'b1);
    step();
    check_state("wrap", 6'd0, 6'd63, word_at(6'd63), 1'b1);
    step();
    check_state("post_wrap", 6'd1, 6'd0, word_at(6'd0), 1'b1);

    // jump and branch together: jump wins (branch alone would give 60)
    jump_en = 1'b1; jump_addr = 6'd10; branch_en = 1'b1; branch_off = 6'b111011;
    step();
    check_state("jmp_over_br", 6'd10, 6'd0, word_at(6'd0), 1'b0);
    jump_en = 1'b0; branch_en = 1'b0;
    step();
    check_state("jmp_over_br_tgt", 6'd11, 6'd10, word_at(6'd10), 1'b1);

    // forward branch: 10 + 1 + 3 = 14
    branch_en = 1'b1; branch_off = 6'd3;
    step();
    check("br_fwd.addr", 32'(addr_code), 32'd14);
    branch_en = 1'b0;
    step();
    check_state("br_fwd_tgt", 6'd15, 6'd14, word_at(6'd14), 1'b1);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    check_state("arst", 6'd0, 6'd0, 32'd0, 1'b0);
    step();
    check_state("arst_hold", 6'd0, 6'd0, 32'd0, 1'b0);
    #3 rst = 1'b0;
    step();
    check_state("arst_resume", 6'd1, 6'd0, word_at(6'd0), 1'b1);

    // halt word at address 4
    halt_at4 = 1'b1;
    step(); step(); step();
    check_state("pre_halt", 6'd4, 6'd3, word_at(6'd3), 1'b1);
    step();
    check("halt.ir", ir, 32'hFFFF_FFFF);
    check("halt.vld", 32'(ir_valid), 32'd1);
    check("halt.ir_pc", 32'(ir_pc), 32'd4);
`ifdef FETCH_HALT_EN
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.addr", 32'(addr_code), 32'd4);
    jump_en = 1'b1; jump_addr = 6'd20;
    step();
    check_state("halted1", 6'd4, 6'd4, 32'hFFFF_FFFF, 1'b0);
    jump_en = 1'b0;
    step();
    check_state("halted2", 6'd4, 6'd4, 32'hFFFF_FFFF, 1'b0);
    jump_en = 1'b1;
    step();
    check_state("halted3", 6'd4, 6'd4, 32'hFFFF_FFFF, 1'b0);
    check("halted3.halted", 32'(halted), 32'd1);
    jump_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("halt_rst.addr", 32'(addr_code), 32'd0);
    check("halt_rst.halted", 32'(halted), 32'd0);
    #10 rst = 1'b0;
`else
    check("nohalt.halted", 32'(halted), 32'd0);
    check("nohalt.addr", 32'(addr_code), 32'd5);
    step();
    check_state("nohalt_next", 6'd6, 6'd5, word_at(6'd5), 1'b1);
    check("nohalt_next.halted", 32'(halted), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
